// File: rtl/intr_icpit_pkg.sv
// Shared definitions for the intr_icpit interrupt controller: register map,
// controller states, the "no vector" code and the fixed-priority encoder.
package intr_icpit_pkg;

  localparam int unsigned NUM_IRQ  = 5;
  localparam logic [2:0]  NONE_VEC = 3'd7;

  localparam logic [2:0] ADDR_MASK  = 3'd0;
  localparam logic [2:0] ADDR_EDGE  = 3'd1;
  localparam logic [2:0] ADDR_PEND  = 3'd2;
  localparam logic [2:0] ADDR_IVEC  = 3'd3;
  localparam logic [2:0] ADDR_STATE = 3'd4;
  localparam logic [2:0] ADDR_EOI   = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    INSERVICE = 2'd2
  } fsm_e;

  // Index of the lowest set bit (bit 0 has highest priority), NONE_VEC if none.
  function automatic logic [2:0] prio_enc(input logic [NUM_IRQ-1:0] v);
    logic [NUM_IRQ-1:0] t;
    logic               found;
    logic [2:0]         idx;
    t     = v;
    found = 1'b0;
    idx   = NONE_VEC;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (t[0] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
      t = t >> 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_icpit_ctrl_sync_edge.sv
// Request capture: optional 2-flop synchroniser (INTR_IREQ_SYNC_EN), then the
// ireq_q / ireq_p pair that yields a one-cycle rising-edge pulse per line.
module intr_sync_edge
  import intr_icpit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] ireq_i,
  output logic [NUM_IRQ-1:0] ireq_q_o,
  output logic [NUM_IRQ-1:0] rise_o
);

  logic [NUM_IRQ-1:0] src;
  logic [NUM_IRQ-1:0] ireq_q, ireq_d;
  logic [NUM_IRQ-1:0] ireq_p_q, ireq_p_d;

`ifdef INTR_IREQ_SYNC_EN
  logic [1:0][NUM_IRQ-1:0] sync_q, sync_d;

  always_comb begin
    sync_d[0] = ireq_i;
    sync_d[1] = sync_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign src = sync_q[1];
`else
  assign src = ireq_i;
`endif

  always_comb begin
    ireq_d   = src;
    ireq_p_d = ireq_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ireq_q   <= '0;
      ireq_p_q <= '0;
    end else begin
      ireq_q   <= ireq_d;
      ireq_p_q <= ireq_p_d;
    end
  end

  assign ireq_q_o = ireq_q;
  assign rise_o   = ireq_q & ~ireq_p_q;

endmodule

// File: rtl/intr_icpit_ctrl.sv
// Five-line interrupt controller: mask, edge/level mode, pending register,
// fixed-priority vector and IACK/EOI handshake. Optional macro: INTR_IREQ_SYNC_EN.
module intr_icpit_ctrl
  import intr_icpit_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [4:0] IREQ,
  output logic       IRQ,
  input  logic       IACK,
  output logic [2:0] IVEC,
  input  logic       SEL,
  input  logic       WRITE,
  input  logic [2:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA
);

  logic [NUM_IRQ-1:0] ireq_q, rise;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_mode_q, edge_mode_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  fsm_e               fsm_q, fsm_d;
  logic               irq_q, irq_d;
  logic [2:0]         ivec_q, ivec_d;

  logic [NUM_IRQ-1:0] svc, w1c, ack_clr;
  logic               wr, eoi;

  intr_sync_edge u_sync (
    .clk      (PCLK),
    .rst      (PRESET),
    .ireq_i   (IREQ),
    .ireq_q_o (ireq_q),
    .rise_o   (rise)
  );

  always_comb begin
    wr          = SEL & WRITE;
    eoi         = wr && (ADDR == ADDR_EOI);
    w1c         = (wr && (ADDR == ADDR_PEND)) ? WDATA[NUM_IRQ-1:0] : '0;
    svc         = pend_q & mask_q;
    mask_d      = (wr && (ADDR == ADDR_MASK)) ? WDATA[NUM_IRQ-1:0] : mask_q;
    edge_mode_d = (wr && (ADDR == ADDR_EDGE)) ? WDATA[NUM_IRQ-1:0] : edge_mode_q;
    fsm_d       = fsm_q;
    irq_d       = irq_q;
    ivec_d      = ivec_q;
    ack_clr     = '0;

    case (fsm_q)
      IDLE: begin
        irq_d = 1'b0;
        if (|svc) begin
          fsm_d = ASSERT;
          irq_d = 1'b1;
        end
      end
      ASSERT: begin
        if (IACK) begin
          ivec_d = prio_enc(svc);
          irq_d  = 1'b0;
          if (|svc) begin
            fsm_d   = INSERVICE;
            // isolate the lowest set bit: the line being acknowledged
            ack_clr = svc & ~(svc - NUM_IRQ'(1));
          end else begin
            fsm_d = IDLE;
          end
        end else if (!(|svc)) begin
          fsm_d = IDLE;
          irq_d = 1'b0;
        end else begin
          irq_d = 1'b1;
        end
      end
      INSERVICE: begin
        irq_d = 1'b0;
        if (eoi) fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
        irq_d = 1'b0;
      end
    endcase

    // edge lines: clears first, then a new rising edge wins; level lines track ireq_q
    pend_d = (edge_mode_q & ((pend_q & ~(w1c | ack_clr)) | rise))
           | (~edge_mode_q & ireq_q);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      mask_q      <= '0;
      edge_mode_q <= '0;
      pend_q      <= '0;
      fsm_q       <= IDLE;
      irq_q       <= 1'b0;
      ivec_q      <= NONE_VEC;
    end else begin
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
      pend_q      <= pend_d;
      fsm_q       <= fsm_d;
      irq_q       <= irq_d;
      ivec_q      <= ivec_d;
    end
  end

  always_comb begin
    RDATA = '0;
    case (ADDR)
      ADDR_MASK:  RDATA = {3'b000, mask_q};
      ADDR_EDGE:  RDATA = {3'b000, edge_mode_q};
      ADDR_PEND:  RDATA = {3'b000, pend_q};
      ADDR_IVEC:  RDATA = {5'b00000, ivec_q};
      ADDR_STATE: RDATA = {6'b000000, fsm_q};
      default:    RDATA = '0;
    endcase
  end

  assign IRQ  = irq_q;
  assign IVEC = ivec_q;

endmodule

// File: tb/tb_intr_icpit_ctrl.sv
// Scoreboard bench for intr_icpit_ctrl: stimulus queues expected values with a
// due cycle; a monitor compares them against the DUT on the falling edge.
module tb_intr_icpit_ctrl;

`ifdef INTR_IREQ_SYNC_EN
  localparam int L = 4;
`else
  localparam int L = 2;
`endif

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [4:0] IREQ = '0;
  logic       IRQ;
  logic       IACK = 1'b0;
  logic [2:0] IVEC;
  logic       SEL = 1'b0;
  logic       WRITE = 1'b0;
  logic [2:0] ADDR = '0;
  logic [7:0] WDATA = '0;
  logic [7:0] RDATA;

  intr_icpit_ctrl dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .IREQ   (IREQ),
    .IRQ    (IRQ),
    .IACK   (IACK),
    .IVEC   (IVEC),
    .SEL    (SEL),
    .WRITE  (WRITE),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .RDATA  (RDATA)
  );

  typedef struct {
    string name;
    int    kind;   // 0 IRQ, 1 IVEC, 2 RDATA at the currently driven ADDR
    int    exp;
    int    due;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        int act;
        case (sbq[i].kind)
          0:       act = int'(IRQ);
          1:       act = int'(IVEC);
          default: act = int'(RDATA);
        endcase
        checks++;
        if (sbq[i].due < cyc) begin
          failures++;
          $display("FAIL %s: missed check, due cycle %0d seen at %0d", sbq[i].name, sbq[i].due, cyc);
        end else if (act != sbq[i].exp) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", sbq[i].name, act, sbq[i].exp, cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic expect_at(input string name, input int kind, input int exp, input int due);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    c.due  = due;
    sbq.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic rd(input logic [2:0] a, input int exp, input string name);
    ADDR = a;
    expect_at(name, 2, exp, cyc);
    tick(1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    SEL = 1'b1; WRITE = 1'b1; ADDR = a; WDATA = d;
    tick(1);
    SEL = 1'b0; WRITE = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] pat);
    IREQ = pat;
    tick(1);
    IREQ = '0;
  endtask

  task automatic iack();
    IACK = 1'b1;
    tick(1);
    IACK = 1'b0;
  endtask

  // Reference: serviced vector is the lowest-numbered pending+enabled line.
  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 7;
  endfunction

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: run did not complete, %0d checks still queued", sbq.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int k, a, b, r, idx, c, c2, d, e, w, guard;
    logic [4:0] lane, pat, exp_pend;
    bit first;

    tick(3);
    PRESET = 1'b0;
    tick(1);

    expect_at("rst_irq", 0, 0, cyc);
    expect_at("rst_ivec", 1, 7, cyc);
    rd(3'd0, 0, "rst_mask");
    rd(3'd1, 0, "rst_edge");
    rd(3'd2, 0, "rst_pend");
    rd(3'd3, 7, "rst_ivec_reg");
    rd(3'd4, 0, "rst_state");

    iack();
    expect_at("spur_ivec", 1, 7, cyc);
    expect_at("spur_irq", 0, 0, cyc);
    rd(3'd4, 0, "spur_state");
    wr(3'd7, 8'hff);
    rd(3'd7, 0, "unmapped7");
    rd(3'd6, 0, "unmapped6");

    // Level lines: assert, then remove by dropping the request or by masking.
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(4, 0);
      lane = 5'd1 << k;
      wr(3'd0, {3'b000, lane});
      wr(3'd1, 8'h00);
      c = cyc;
      IREQ = lane;
      expect_at("lvl_irq_early", 0, 0, c + L);
      expect_at("lvl_irq_rise", 0, 1, c + L + 1);
      tick(L + 2);
      rd(3'd4, 1, "lvl_state_assert");
      if (it[0]) begin
        d = cyc;
        IREQ = '0;
        expect_at("lvl_drop_hold", 0, 1, d + L);
        expect_at("lvl_drop_irq", 0, 0, d + L + 1);
        tick(L + 2);
      end else begin
        w = cyc;
        expect_at("mask_irq_hold", 0, 1, w + 1);
        expect_at("mask_irq_drop", 0, 0, w + 2);
        wr(3'd0, 8'h00);
        IREQ = '0;
        tick(L + 2);
      end
      rd(3'd4, 0, "lvl_state_idle");
      rd(3'd2, 0, "lvl_pend_clear");
    end

    // Edge lines: two simultaneous requests, priority service, INSERVICE blocking.
    wr(3'd0, 8'h1f);
    wr(3'd1, 8'h1f);
    a = $urandom_range(4, 0);
    do b = $urandom_range(4, 0); while (b == a);
    pat = (5'd1 << a) | (5'd1 << b);
    c = cyc;
    expect_at("pri_irq_early", 0, 0, c + L);
    expect_at("pri_irq", 0, 1, c + L + 1);
    pulse(pat);
    tick(L + 1);
    exp_pend = pat;
    rd(3'd2, int'(exp_pend), "pri_pend");

    first = 1'b1;
    guard = 0;
    while (exp_pend != '0 && guard < 8) begin
      guard++;
      expect_at("svc_irq_on", 0, 1, cyc);
      iack();
      idx = lowest(exp_pend);
      exp_pend = exp_pend & ~(5'd1 << idx);
      expect_at("ack_ivec", 1, idx, cyc);
      expect_at("ack_irq_off", 0, 0, cyc);
      rd(3'd2, int'(exp_pend), "ack_pend");
      rd(3'd4, 2, "ack_state_insvc");
      if (first) begin
        first = 1'b0;
        do r = $urandom_range(4, 0); while (exp_pend[r]);
        c2 = cyc;
        for (int j = 1; j <= L + 3; j++) expect_at("insvc_irq_blocked", 0, 0, c2 + j);
        pulse(5'd1 << r);
        tick(L + 1);
        exp_pend = exp_pend | (5'd1 << r);
        rd(3'd2, int'(exp_pend), "insvc_pend");
      end
      e = cyc;
      expect_at("eoi_irq_gap", 0, 0, e + 1);
      expect_at("eoi_irq_next", 0, int'(exp_pend != '0), e + 2);
      wr(3'd5, 8'h00);
      tick(1);
    end
    rd(3'd2, 0, "final_pend");
    rd(3'd4, 0, "final_state");

    // Edge set colliding with W1C of the same bit: the set must win.
    wr(3'd0, 8'h00);
    k = $urandom_range(4, 0);
    lane = 5'd1 << k;
    pulse(lane);
    tick(L + 1);
    rd(3'd2, int'(lane), "col_pre_pend");
    pulse(lane);
    tick(L - 2);
    wr(3'd2, {3'b000, lane});
    tick(1);
    rd(3'd2, int'(lane), "w1c_collision");
    wr(3'd2, {3'b000, lane});
    rd(3'd2, 0, "w1c_clear");
    wr(3'd1, 8'h00);
    IREQ = lane;
    tick(L + 2);
    wr(3'd2, 8'h1f);
    rd(3'd2, int'(lane), "w1c_level_ignored");
    IREQ = '0;
    tick(L + 2);
    rd(3'd2, 0, "level_pend_follow");

    // Reset asserted while an interrupt is being asserted.
    pat = 5'($urandom_range(31, 1));
    wr(3'd0, 8'h1f);
    wr(3'd1, {3'b000, ~pat});
    IREQ = pat;
    tick(L + 2);
    expect_at("pre_rst_irq", 0, 1, cyc);
    rd(3'd4, 1, "pre_rst_state");
    PRESET = 1'b1;
    expect_at("rst_mid_irq", 0, 0, cyc);
    expect_at("rst_mid_ivec", 1, 7, cyc);
    rd(3'd0, 0, "rst_mid_mask");
    rd(3'd1, 0, "rst_mid_edge");
    rd(3'd2, 0, "rst_mid_pend");
    rd(3'd4, 0, "rst_mid_state");
    IREQ = '0;
    PRESET = 1'b0;
    tick(3);

    if (sbq.size() != 0) begin
      checks += sbq.size();
      failures += sbq.size();
      $display("FAIL leftover: %0d checks never reached, required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
